keypad_entry: RTL
=================

// Module: keypad_entry
// PURPOSE
//   Numeric entry front end; the input-side counterpart of the multiplexed 7-seg number display.
//   Scans a 4x4 active-low matrix keypad, debounces and decodes keys, and collects up to
//   MAX_DIGITS decimal digits as BCD. On ENTER it converts the BCD digits into a 32-bit binary
//   value, which feeds the display/number path (e.g. threshold or gain setpoints).
// PARAMETERS
//   SCAN_DIV       50000  clk cycles each column is driven (column dwell)
//   DEBOUNCE_SCANS 4      consecutive identical full scans (frames) needed to accept press/release
//   MAX_DIGITS     8      max digits held; 8 keeps num <= 99_999_999 (fits 32 bits and 8-digit display)
// PORTS
//   clk          in   1              system clock
//   rst_n        in   1              reset, asynchronous, active-low
//   row_n        in   4              keypad rows, active-low, asynchronous to clk
//   col_n        out  4              keypad column drive, active-low, one-hot-zero
//   key_strobe   out  1              1-cycle pulse on each accepted key press
//   key_code     out  4              {row[1:0],col[1:0]} of last accepted key
//   bcd          out  4*MAX_DIGITS   digits being entered, LS digit in [3:0] (live echo)
//   digit_count  out  4              number of digits held, 0..MAX_DIGITS
//   busy         out  1              BCD->binary conversion in progress
//   num          out  32             last converted value
//   num_valid    out  1              1-cycle pulse when num updates
// BEHAVIOUR
//   Reset (async): col_n=4'b1110, every other output 0, FSM=IDLE, all counters 0.
//   row_n passes through a 2-flop synchronizer before use.
//   Scan: dwell counter 0..SCAN_DIV-1; sample synced rows on its last cycle, then advance column
//     0->1->2->3->0. A frame is 4 columns. Frame result: exactly one key low -> that code;
//     none -> NONE; two or more -> NONE (ghost/multi-press rejected).
//   Debounce FSM, evaluated once per frame:
//     IDLE:    key K -> PRESS_CAND(K, cnt=1).
//     PRESS_CAND: same K -> cnt++; cnt==DEBOUNCE_SCANS -> PRESSED, key_strobe=1, key_code=K;
//              different key or NONE -> IDLE.
//     PRESSED: NONE -> RELEASE_CAND(cnt=1); any key -> stay (no auto-repeat).
//     RELEASE_CAND: NONE -> cnt++; cnt==DEBOUNCE_SCANS -> IDLE; any key -> PRESSED.
//   Key map (row,col): r0:1 2 3 CLR | r1:4 5 6 BKSP | r2:7 8 9 - | r3:- 0 - ENT. '-' keys strobe,
//     no action.
//   Actions in the key_strobe cycle, register updates visible the next cycle:
//     digit d: if digit_count<MAX_DIGITS: bcd<={bcd[..-5:0],d}, count++; else dropped (count held).
//              Leading zeros are counted as digits.
//     BKSP: bcd>>=4, count-- (no-op at 0). CLR: bcd=0, count=0. num is unchanged by all three.
//     ENT:  start conversion; bcd/digit_count cleared in the same cycle as the start.
//   Conversion: busy=1 for exactly MAX_DIGITS cycles; acc=acc*10+digit, MS digit first,
//     *10 as (acc<<3)+(acc<<1), 32-bit. Then num<=acc, num_valid pulses the cycle busy falls.
//     ENT with count 0 yields num=0 plus a num_valid pulse.
//   Key actions whose strobe falls while busy=1 are dropped; key_strobe/key_code still update.
//   Reset mid-operation aborts the scan and any conversion; num returns to 0.
// STRUCTURE
//   Shared package: key-code constants (KEY_CLR=4'h3, KEY_BKSP=4'h7, KEY_ENT=4'hF),
//     debounce FSM state enum, digit lookup table.
//   Sub-module: keypad_bcd2bin (sequential MAX_DIGITS-cycle BCD->binary converter, start/busy/done).
//   Scanner, synchronizer, debounce FSM and entry register stay in keypad_entry.
// TESTING  (SCAN_DIV=4, DEBOUNCE_SCANS=3 for sim; key held >= 5 frames, released >= 5 frames)
//   Keys 1,2,3,ENT -> bcd=32'h00000123, count=3; num=123 + one num_valid within 10 cycles of ENT.
//   Row pulse held only 2 frames, or bouncing every frame -> no key_strobe, bcd unchanged.
//   Nine '9' keys -> count=8, ninth dropped; ENT -> num=99999999.
//   4,5,BKSP -> bcd=4, count=1; CLR -> 0/0; ENT -> num=0 with a num_valid pulse.
//   Keys (r0,c0)+(r1,c0) held together -> no strobe; one key held 20 frames -> exactly one strobe.
//   rst_n low during busy -> immediately num=0, busy=0, col_n=1110; no num_valid after release.

Source files
------------

// File: rtl/keypad_entry_pkg.sv
// rtl/keypad_entry_pkg.sv - shared key codes, debounce states and digit decode
// Key codes are {row[1:0],col[1:0]} of the 4x4 matrix.
package keypad_entry_pkg;

  localparam logic [3:0] KEY_CLR  = 4'h3;
  localparam logic [3:0] KEY_BKSP = 4'h7;
  localparam logic [3:0] KEY_ENT  = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_CAND,
    ST_PRESSED,
    ST_RELEASE_CAND
  } deb_state_e;

  // Returns {is_digit, digit}; non-digit keys come back with bit 4 clear.
  function automatic logic [4:0] key_digit(input logic [3:0] code);
    logic [4:0] r;
    case (code)
      4'h0:    r = {1'b1, 4'd1};
      4'h1:    r = {1'b1, 4'd2};
      4'h2:    r = {1'b1, 4'd3};
      4'h4:    r = {1'b1, 4'd4};
      4'h5:    r = {1'b1, 4'd5};
      4'h6:    r = {1'b1, 4'd6};
      4'h8:    r = {1'b1, 4'd7};
      4'h9:    r = {1'b1, 4'd8};
      4'hA:    r = {1'b1, 4'd9};
      4'hD:    r = {1'b1, 4'd0};
      default: r = 5'd0;
    endcase
    return r;
  endfunction

  // acc*10 + d without a multiplier.
  function automatic logic [31:0] times10_add(input logic [31:0] acc, input logic [3:0] d);
    return (acc << 3) + (acc << 1) + {28'd0, d};
  endfunction

endpackage

// File: rtl/keypad_entry_if.sv
// rtl/keypad_entry_if.sv - keypad matrix lines and entry results bundle
// master is the entry block, slave is the keypad/consumer side.
interface keypad_entry_if #(
  parameter int MAX_DIGITS = 8
);
  logic [3:0]              row_n;
  logic [3:0]              col_n;
  logic                    key_strobe;
  logic [3:0]              key_code;
  logic [4*MAX_DIGITS-1:0] bcd;
  logic [3:0]              digit_count;
  logic                    busy;
  logic [31:0]             num;
  logic                    num_valid;

  modport master (
    input  row_n,
    output col_n, key_strobe, key_code, bcd, digit_count, busy, num, num_valid
  );

  modport slave (
    output row_n,
    input  col_n, key_strobe, key_code, bcd, digit_count, busy, num, num_valid
  );
endinterface

// File: rtl/keypad_bcd2bin.sv
// rtl/keypad_bcd2bin.sv - sequential BCD to binary converter, one digit per cycle
// MS digit first; result and done update on the cycle busy falls.
module keypad_bcd2bin
  import keypad_entry_pkg::*;
#(
  parameter int MAX_DIGITS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic [4*MAX_DIGITS-1:0] bcd_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [31:0]             result_o
);

  localparam int IDX_W = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;

  logic [4*MAX_DIGITS-1:0] shreg_q;
  logic [31:0]             acc_q;
  logic [31:0]             acc_d;
  logic [IDX_W-1:0]        idx_q;
  logic                    busy_q;
  logic                    done_q;
  logic [31:0]             result_q;

  assign acc_d = times10_add(acc_q, shreg_q[4*MAX_DIGITS-1 -: 4]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q  <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (start_i && !busy_q) begin
        shreg_q <= bcd_i;
        acc_q   <= '0;
        idx_q   <= '0;
        busy_q  <= 1'b1;
      end else if (busy_q) begin
        acc_q   <= acc_d;
        shreg_q <= shreg_q << 4;
        idx_q   <= idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(MAX_DIGITS - 1)) begin
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          result_q <= acc_d;
        end
      end
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: rtl/keypad_entry.sv
// rtl/keypad_entry.sv - 4x4 keypad scanner, debouncer and BCD digit entry
// Frames of four column dwells feed a once-per-frame debounce FSM.
module keypad_entry
  import keypad_entry_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int MAX_DIGITS     = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  keypad_entry_if.master kp
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

  logic [3:0]       row_s1_q, row_s2_q;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       col_q;
  logic [1:0]       hits_q;
  logic [3:0]       fcode_q;

  logic       sample, frame_end;
  logic [3:0] col_low;
  logic [2:0] col_hits;
  logic [1:0] col_row;
  logic [2:0] hits_sum;
  logic [1:0] hits_d;
  logic [3:0] fcode_d;
  logic       fkey_valid;

  always_comb begin
    col_low  = ~row_s2_q;
    col_hits = 3'd0;
    col_row  = 2'd0;
    for (int r = 0; r < 4; r++) begin
      if (col_low[r]) begin
        col_hits = col_hits + 3'd1;
        col_row  = 2'(r);
      end
    end
    // Hit count saturates at 2: anything beyond one key is a reject.
    hits_sum   = {1'b0, hits_q} + col_hits;
    hits_d     = (hits_sum >= 3'd2) ? 2'd2 : hits_sum[1:0];
    fcode_d    = (col_hits == 3'd1) ? {col_row, col_q} : fcode_q;
    sample     = (div_q == DIV_W'(SCAN_DIV - 1));
    frame_end  = sample && (col_q == 2'd3);
    fkey_valid = (hits_d == 2'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1_q <= 4'hF;
      row_s2_q <= 4'hF;
      div_q    <= '0;
      col_q    <= 2'd0;
      hits_q   <= 2'd0;
      fcode_q  <= 4'd0;
    end else begin
      row_s1_q <= kp.row_n;
      row_s2_q <= row_s1_q;
      if (sample) begin
        div_q   <= '0;
        col_q   <= col_q + 2'd1;
        hits_q  <= frame_end ? 2'd0 : hits_d;
        fcode_q <= fcode_d;
      end else begin
        div_q <= div_q + DIV_W'(1);
      end
    end
  end

  deb_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       cand_q;
  logic             key_strobe_q;
  logic [3:0]       key_code_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      cand_q       <= 4'd0;
      key_strobe_q <= 1'b0;
      key_code_q   <= 4'd0;
    end else begin
      key_strobe_q <= 1'b0;
      if (frame_end) begin
        case (state_q)
          ST_IDLE: begin
            if (fkey_valid) begin
              cand_q <= fcode_d;
              cnt_q  <= CNT_W'(1);
              if (DEBOUNCE_SCANS <= 1) begin
                state_q      <= ST_PRESSED;
                key_strobe_q <= 1'b1;
                key_code_q   <= fcode_d;
              end else begin
                state_q <= ST_PRESS_CAND;
              end
            end
          end
          ST_PRESS_CAND: begin
            if (fkey_valid && fcode_d == cand_q) begin
              cnt_q <= cnt_q + CNT_W'(1);
              if (cnt_q + CNT_W'(1) == CNT_W'(DEBOUNCE_SCANS)) begin
                state_q      <= ST_PRESSED;
                key_strobe_q <= 1'b1;
                key_code_q   <= cand_q;
              end
            end else begin
              state_q <= ST_IDLE;
            end
          end
          ST_PRESSED: begin
            if (!fkey_valid) begin
              cnt_q   <= CNT_W'(1);
              state_q <= (DEBOUNCE_SCANS <= 1) ? ST_IDLE : ST_RELEASE_CAND;
            end
          end
          ST_RELEASE_CAND: begin
            if (!fkey_valid) begin
              cnt_q <= cnt_q + CNT_W'(1);
              if (cnt_q + CNT_W'(1) == CNT_W'(DEBOUNCE_SCANS)) state_q <= ST_IDLE;
            end else begin
              state_q <= ST_PRESSED;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  logic [4*MAX_DIGITS-1:0] bcd_q;
  logic [3:0]              count_q;
  logic                    conv_busy, conv_done;
  logic [31:0]             conv_result;
  logic                    act, conv_start;
  logic [4:0]              dlu;

  assign act        = key_strobe_q && !conv_busy;
  assign conv_start = act && (key_code_q == KEY_ENT);
  assign dlu        = key_digit(key_code_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_q   <= '0;
      count_q <= 4'd0;
    end else if (act) begin
      if (dlu[4]) begin
        if (count_q < 4'(MAX_DIGITS)) begin
          bcd_q   <= {bcd_q[4*MAX_DIGITS-5:0], dlu[3:0]};
          count_q <= count_q + 4'd1;
        end
      end else if (key_code_q == KEY_BKSP) begin
        if (count_q != 4'd0) begin
          bcd_q   <= bcd_q >> 4;
          count_q <= count_q - 4'd1;
        end
      end else if (key_code_q == KEY_CLR || key_code_q == KEY_ENT) begin
        // The converter latches the digits at start, so clearing here is safe.
        bcd_q   <= '0;
        count_q <= 4'd0;
      end
    end
  end

  keypad_bcd2bin #(
    .MAX_DIGITS(MAX_DIGITS)
  ) u_bcd2bin (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (conv_start),
    .bcd_i   (bcd_q),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .result_o(conv_result)
  );

  assign kp.col_n       = ~(4'b0001 << col_q);
  assign kp.key_strobe  = key_strobe_q;
  assign kp.key_code    = key_code_q;
  assign kp.bcd         = bcd_q;
  assign kp.digit_count = count_q;
  assign kp.busy        = conv_busy;
  assign kp.num         = conv_result;
  assign kp.num_valid   = conv_done;

endmodule
